// File: rtl/multicycle_alu.sv
// multicycle_alu: single-cycle logic/arith/shift ops plus iterative signed
// Booth multiply and an optional signed restoring divider.
// Optional feature macro: MULTICYCLE_ALU_DIV_EN (builds the divider and DIV state).
module multicycle_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   A_reg,
  input  logic [WIDTH-1:0]   B_reg,
  output logic [2*WIDTH-1:0] C_reg,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic               illegal
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
`ifdef MULTICYCLE_ALU_DIV_EN
  localparam logic [4:0] OP_DIV  = 5'b10000;
`endif

`ifdef MULTICYCLE_ALU_DIV_EN
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;
`endif

  state_t               state_q;
  logic [2*WIDTH-1:0]   c_q;
  logic                 busy_q, done_q, dz_q, ill_q;
  logic [CW-1:0]        cnt_q;

  // ---------------- single-cycle datapath ----------------
  logic [SHW-1:0]   amt;
  int unsigned      amt_u;
  logic [WIDTH-1:0] ror_v, rol_v, sc_res;
  logic             sc_ill;

  // Combinational result for every non-iterative opcode; unlisted opcodes flag illegal.
  always_comb begin
    amt    = B_reg[SHW-1:0];
    amt_u  = 32'(amt);
    ror_v  = '0;
    rol_v  = '0;
    // Rotates as index remaps so a rotate by 0 naturally returns A.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ror_v[IW'(i)] = A_reg[IW'((i + amt_u) % WIDTH)];
      rol_v[IW'(i)] = A_reg[IW'((i + WIDTH - (amt_u % WIDTH)) % WIDTH)];
    end
    sc_res = '0;
    sc_ill = 1'b0;
    case (opcode)
      OP_ADD:  sc_res = A_reg + B_reg;
      OP_SUB:  sc_res = A_reg - B_reg;
      OP_AND:  sc_res = A_reg & B_reg;
      OP_OR:   sc_res = A_reg | B_reg;
      OP_SHR:  sc_res = A_reg >> amt;
      OP_SHRA: sc_res = $signed(A_reg) >>> amt;
      OP_SHL:  sc_res = A_reg << amt;
      OP_ROR:  sc_res = ror_v;
      OP_ROL:  sc_res = rol_v;
      OP_NEG:  sc_res = ~B_reg + WIDTH'(1);
      OP_NOT:  sc_res = ~B_reg;
      default: begin
        sc_res = '0;
        sc_ill = 1'b1;
      end
    endcase
  end

  // ---------------- Booth multiplier ----------------
  // Accumulator carries one guard bit so subtracting the most negative
  // multiplicand cannot overflow.
  logic [WIDTH:0]   mhi_q, mhi_sum, mhi_d;
  logic [WIDTH-1:0] mlo_q, mlo_d, mcand_q;
  logic             mq_q, mq_d;

  // One radix-2 Booth step: add/subtract multiplicand, then arithmetic shift right.
  always_comb begin
    case ({mlo_q[0], mq_q})
      2'b01:   mhi_sum = mhi_q + {mcand_q[WIDTH-1], mcand_q};
      2'b10:   mhi_sum = mhi_q - {mcand_q[WIDTH-1], mcand_q};
      default: mhi_sum = mhi_q;
    endcase
    mhi_d = {mhi_sum[WIDTH], mhi_sum[WIDTH:1]};
    mlo_d = {mhi_sum[0], mlo_q[WIDTH-1:1]};
    mq_d  = mlo_q[0];
  end

`ifdef MULTICYCLE_ALU_DIV_EN
  // ---------------- restoring divider ----------------
  // Divides magnitudes unsigned, then applies signs: quotient negated when
  // operand signs differ, remainder follows the sign of A.
  logic [WIDTH-1:0] drem_q, drem_d, dquo_q, dquo_d, ddiv_q;
  logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;
  logic             dqneg_q, drneg_q, dge;
  logic [WIDTH:0]   dtrial, dsub;

  assign a_abs = A_reg[WIDTH-1] ? -A_reg : A_reg;
  assign b_abs = B_reg[WIDTH-1] ? -B_reg : B_reg;

  // One restoring step; the partial remainder stays below the divisor, so
  // the top bit of the subtraction is exactly the borrow.
  always_comb begin
    dtrial = {drem_q, dquo_q[WIDTH-1]};
    dsub   = dtrial - {1'b0, ddiv_q};
    dge    = ~dsub[WIDTH];
    drem_d = dge ? dsub[WIDTH-1:0] : dtrial[WIDTH-1:0];
    dquo_d = {dquo_q[WIDTH-2:0], dge};
    q_fix  = dqneg_q ? -dquo_d : dquo_d;
    r_fix  = drneg_q ? -drem_d : drem_d;
  end
`endif

  // Control FSM with registered outputs; also sequences the iterative datapaths.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
          if (start) begin
            case (opcode)
              OP_MUL: begin
                state_q <= ST_MUL;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                mhi_q   <= '0;
                mlo_q   <= B_reg;
                mq_q    <= 1'b0;
                mcand_q <= A_reg;
              end
`ifdef MULTICYCLE_ALU_DIV_EN
              OP_DIV: begin
                if (B_reg == '0) begin
                  c_q     <= {A_reg, {WIDTH{1'b1}}};
                  dz_q    <= 1'b1;
                  ill_q   <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
                end else begin
                  state_q <= ST_DIV;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  drem_q  <= '0;
                  dquo_q  <= a_abs;
                  ddiv_q  <= b_abs;
                  dqneg_q <= A_reg[WIDTH-1] ^ B_reg[WIDTH-1];
                  drneg_q <= A_reg[WIDTH-1];
                end
              end
`endif
              default: begin
                c_q     <= {{WIDTH{1'b0}}, sc_res};
                ill_q   <= sc_ill;
                dz_q    <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end
            endcase
          end
        end
        ST_MUL: begin
          mhi_q <= mhi_d;
          mlo_q <= mlo_d;
          mq_q  <= mq_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            c_q     <= {mhi_d[WIDTH-1:0], mlo_d};
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dz_q    <= 1'b0;
            ill_q   <= 1'b0;
            state_q <= ST_DONE;
          end
        end
`ifdef MULTICYCLE_ALU_DIV_EN
        ST_DIV: begin
          drem_q <= drem_d;
          dquo_q <= dquo_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            c_q     <= {r_fix, q_fix};
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dz_q    <= 1'b0;
            ill_q   <= 1'b0;
            state_q <= ST_DONE;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign C_reg    = c_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign illegal  = ill_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=32): directed cases plus
// randomized operations against an arithmetic reference model.
module tb_multicycle_alu;

  logic        clk;
  logic        clear;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] A_reg, B_reg;
  logic [63:0] C_reg;
  logic        busy, done, div_zero, illegal;

  int tests = 0;
  int fails = 0;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk(clk), .clear(clear), .start(start), .opcode(opcode),
    .A_reg(A_reg), .B_reg(B_reg), .C_reg(C_reg),
    .busy(busy), .done(done), .div_zero(div_zero), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [4:0] legal_ops [13] = '{5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
                                 5'h0A, 5'h0B, 5'h0F, 5'h10, 5'h11, 5'h12};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] c, output logic dz, output logic ill,
                                output int lat);
    longint     sa, sb, q, r;
    logic [4:0] amt;
    logic [63:0] dbl, tmp;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    amt = b[4:0];
    dbl = {a, a};
    c = '0; dz = 1'b0; ill = 1'b0; lat = 1;
    case (op)
      5'h03: c = {32'h0, a + b};
      5'h04: c = {32'h0, a - b};
      5'h05: c = {32'h0, a & b};
      5'h06: c = {32'h0, a | b};
      5'h07: c = {32'h0, a >> amt};
      5'h08: c = {32'h0, $signed(a) >>> amt};
      5'h09: c = {32'h0, a << amt};
      5'h0A: begin tmp = dbl >> amt; c = {32'h0, tmp[31:0]}; end
      5'h0B: begin tmp = dbl << amt; c = {32'h0, tmp[63:32]}; end
      5'h0F: begin c = sa * sb; lat = 33; end
`ifdef MULTICYCLE_ALU_DIV_EN
      5'h10: begin
        if (b == 32'h0) begin
          c = {a, 32'hFFFFFFFF}; dz = 1'b1;
        end else begin
          q = sa / sb; r = sa % sb;
          c = {r[31:0], q[31:0]}; lat = 33;
        end
      end
`endif
      5'h11: c = {32'h0, -b};
      5'h12: c = {32'h0, ~b};
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit chk_after, output logic [63:0] got);
    logic [63:0] ec, c0;
    logic        edz, eill, dz0, ill0;
    int          elat, cyc, bcyc;
    bit          held;
    model(op, a, b, ec, edz, eill, elat);
    @(negedge clk);
    c0 = C_reg; dz0 = div_zero; ill0 = illegal;
    start = 1'b1; opcode = op; A_reg = a; B_reg = b;
    @(posedge clk); #1;
    start = 1'b0; opcode = 5'($urandom); A_reg = $urandom; B_reg = $urandom;
    cyc = 1; bcyc = 0; held = 1'b1;
    while (!done && cyc < 100) begin
      if (busy) bcyc++;
      if (C_reg !== c0 || div_zero !== dz0 || illegal !== ill0) held = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    got = C_reg;
    check({tag, ".done"}, 64'(done), 64'(1));
    check({tag, ".lat"}, 64'(cyc), 64'(elat));
    check({tag, ".busycyc"}, 64'(bcyc), 64'(elat - 1));
    check({tag, ".held"}, 64'(held), 64'(1));
    check({tag, ".busy_at_done"}, 64'(busy), 64'(0));
    check({tag, ".C"}, C_reg, ec);
    check({tag, ".div_zero"}, 64'(div_zero), 64'(edz));
    check({tag, ".illegal"}, 64'(illegal), 64'(eill));
    if (chk_after) begin
      @(posedge clk); #1;
      check({tag, ".done_pulse"}, 64'(done), 64'(0));
      check({tag, ".C_hold"}, C_reg, ec);
    end
  endtask

  initial begin
    logic [63:0] got;
    logic [4:0]  op;
    logic [31:0] a, b;
    bit          seen_done;

    clear = 1'b1; start = 1'b0; opcode = '0; A_reg = '0; B_reg = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.C", C_reg, 64'h0);
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.done", 64'(done), 64'(0));
    check("rst.div_zero", 64'(div_zero), 64'(0));
    check("rst.illegal", 64'(illegal), 64'(0));
    @(negedge clk); clear = 1'b0;

    run_op(5'h03, 32'hFFFFFFFF, 32'h2, "add_wrap", 1, got);
    check("add_wrap.lit", got, 64'h1);
    run_op(5'h0F, 32'hFFFFFFFD, 32'h7, "mul_neg", 1, got);
    check("mul_neg.lit", got, 64'hFFFFFFFF_FFFFFFEB);
    run_op(5'h0F, 32'h80000000, 32'h80000000, "mul_min", 1, got);
    check("mul_min.lit", got, 64'h40000000_00000000);
    run_op(5'h10, 32'd100, 32'd7, "div_pos", 1, got);
`ifdef MULTICYCLE_ALU_DIV_EN
    check("div_pos.lit", got, 64'h00000002_0000000E);
`endif
    run_op(5'h10, 32'hFFFFFFF9, 32'd2, "div_neg", 1, got);
`ifdef MULTICYCLE_ALU_DIV_EN
    check("div_neg.lit", got, 64'hFFFFFFFF_FFFFFFFD);
`endif
    run_op(5'h10, 32'd5, 32'd0, "div_zero", 1, got);
`ifdef MULTICYCLE_ALU_DIV_EN
    check("div_zero.lit", got, 64'h00000005_FFFFFFFF);
`endif
    run_op(5'h0B, 32'h80000001, 32'h21, "rol1", 1, got);
    check("rol1.lit", got, 64'h3);
    run_op(5'h08, 32'h80000000, 32'h4, "shra", 1, got);
    check("shra.lit", got, 64'hF8000000);
    run_op(5'h0A, 32'h12345678, 32'h20, "ror0", 1, got);
    check("ror0.lit", got, 64'h12345678);
    run_op(5'h1F, 32'h1234, 32'h5678, "illegal", 1, got);
    check("illegal.lit", got, 64'h0);
    run_op(5'h11, 32'h0, 32'h1, "neg", 1, got);

    // Back-to-back: second start is accepted while the first is in DONE.
    run_op(5'h04, 32'h5, 32'h7, "b2b_sub", 0, got);
    run_op(5'h0F, 32'h00010000, 32'hFFFF0000, "b2b_mul", 1, got);

    // Abort: MUL in flight, ignored start at cycle 5, clear at cycle 10.
    seen_done = 1'b0;
    @(negedge clk);
    start = 1'b1; opcode = 5'h0F; A_reg = 32'h7; B_reg = 32'h9;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
      if (cyc == 10) check("abort.busy_before_clear", 64'(busy), 64'(1));
      @(negedge clk);
      start = (cyc == 5); opcode = 5'h03;
      clear = (cyc == 10);
    end
    @(posedge clk); #1;
    clear = 1'b0; start = 1'b0;
    check("abort.no_done", 64'(seen_done), 64'(0));
    check("abort.C", C_reg, 64'h0);
    check("abort.busy", 64'(busy), 64'(0));
    check("abort.done", 64'(done), 64'(0));
    check("abort.flags", {62'h0, div_zero, illegal}, 64'h0);

    // Clear wins over a simultaneous start.
    run_op(5'h12, 32'h0, 32'h0, "pre_clr", 1, got);
    @(negedge clk);
    clear = 1'b1; start = 1'b1; opcode = 5'h03; A_reg = 32'h1; B_reg = 32'h1;
    @(posedge clk); #1;
    check("clr_start.done", 64'(done), 64'(0));
    check("clr_start.C", C_reg, 64'h0);
    @(negedge clk); clear = 1'b0; start = 1'b0;

    for (int n = 0; n < 40; n++) begin
      op = legal_ops[$urandom_range(0, 12)];
      if ($urandom_range(0, 7) == 0) op = 5'($urandom);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'h0;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      run_op(op, a, b, $sformatf("rnd%0d_op%02h", n, op), (n % 3) == 0, got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal values are even numbers from 8 to 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width in bits.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 clear  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  request strobe; sampled only when the block is ready (IDLE or DONE).
REQ-006 opcode  input  5  operation select, sampled with start.
REQ-007 A_reg  input  WIDTH  operand A, sampled with start.
REQ-008 B_reg  input  WIDTH  operand B, sampled with start.
REQ-009 C_reg  output  2*WIDTH  registered result; held stable until the next accepted start.
REQ-010 busy  output  1  high while an iterative operation (MUL, DIV) is in progress.
REQ-011 done  output  1  one-cycle pulse marking C_reg valid.
REQ-012 div_zero  output  1  valid with done; high when DIV had B_reg=0.
REQ-013 illegal  output  1  valid with done; high for an unlisted opcode, or for DIV when the divider is compiled out.

Function
REQ-014 Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010.
REQ-015 FSM states are IDLE, MUL, DIV and DONE; start is accepted only in IDLE or DONE, and start is ignored in MUL or DIV.
REQ-016 Single-cycle ops: an accepted start loads C_reg and enters DONE at the same edge; done is high for the following cycle.
REQ-017 MUL: signed radix-2 Booth, one iteration per cycle over WIDTH cycles; C_reg = full 2*WIDTH signed product; done is high in cycle WIDTH+1 after acceptance.
REQ-018 DIV: signed restoring divide over WIDTH cycles; C_reg = {remainder, quotient}; quotient truncates toward zero and the remainder takes the sign of A; done timing matches MUL.
REQ-019 DIV with B_reg=0: no iteration; completes like a single-cycle op with quotient all-ones, remainder = A_reg and div_zero=1.
REQ-020 For ADD, SUB, AND, OR, NEG (~B+1) and NOT (~B), the result goes to C_reg[WIDTH-1:0] and the upper half is 0; ADD and SUB wrap modulo 2^WIDTH.
REQ-021 Shifts and rotates use the shift amount B_reg[SHW-1:0] only; SHRA sign-fills; ROR/ROL by 0 return A; the upper half of C_reg is 0.
REQ-022 Unlisted opcode: completes like a single-cycle op with C_reg=0 and illegal=1.
REQ-023 DONE returns to IDLE after one cycle unless start is accepted in that cycle, in which case the new operation begins directly (back-to-back).
REQ-024 Operands are captured at acceptance; changes on A_reg, B_reg or opcode mid-operation have no effect.
REQ-025 div_zero and illegal are updated only at completion and are held with C_reg.

Reset
REQ-026 clear at any rising edge forces IDLE, C_reg=0, busy=0, done=0, div_zero=0 and illegal=0.
REQ-027 clear during MUL or DIV aborts the operation with no done pulse; clear overrides a simultaneous start.

Configuration
REQ-028 Macro MULTICYCLE_ALU_DIV_EN defined: the divider and the DIV state are built and DIV behaves per REQ-018/019.
REQ-029 Macro MULTICYCLE_ALU_DIV_EN undefined: no divider logic or DIV state; opcode 10000 behaves per REQ-022 (C_reg=0, illegal=1, div_zero=0).

Verification (WIDTH=32)
REQ-030 ADD A=0xFFFFFFFF, B=2 -> C_reg=0x00000000_00000001, done one cycle after acceptance, busy never high.
REQ-031 MUL A=0xFFFFFFFD (-3), B=7 -> C_reg=0xFFFFFFFF_FFFFFFEB; busy high for 32 cycles; done in cycle 33.
REQ-032 DIV A=100, B=7 -> C_reg=0x00000002_0000000E; DIV A=-7, B=2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV A=5, B=0 -> div_zero=1, quotient 0xFFFFFFFF, remainder 5.
REQ-033 ROL A=0x80000001, B=0x21 (shift amount 1) -> C_reg low half=0x00000003; SHRA A=0x80000000, B=4 -> 0xF8000000.
REQ-034 Start MUL, pulse start again at cycle 5, then assert clear at cycle 10 -> second start ignored, no done pulse, all outputs 0 at the next edge.
REQ-035 Opcode 11111 -> illegal=1, C_reg=0; with the macro undefined, opcode 10000 -> illegal=1.
